// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the configurable UART blocks.
//   parity_e    : parity mode of a frame (none / even / odd)
//   rx_state_e  : receiver frame-tracking states
//   calc_parity : expected parity bit for a data word (0 when no parity)
// Data words narrower than MAX_DATA_BITS are passed zero-extended; the
// extra zeros do not change the XOR.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input parity_e                  mode);
        logic w_xor;
        w_xor = ^data;
        case (mode)
            PARITY_EVEN: return w_xor;
            PARITY_ODD:  return ~w_xor;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Restartable symbol-period counter shared by the UART receiver and
// transmitter. The count wraps to 0 after SYMBOL_TIME-1 and can be forced
// back to 0 at any time so that symbol timing aligns to a detected edge.
// Ports:
//   clk           : system clock
//   i_srst        : synchronous active-high reset
//   i_clear       : restart the count at 0 on the next clock
//   o_sample      : strobe while the count equals SAMPLE_AT
//   o_symbol_edge : strobe on the last count of a symbol period
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int SYMBOL_TIME = 1085,
    parameter int SAMPLE_AT   = 542
) (
    input  logic clk,
    input  logic i_srst,
    input  logic i_clear,
    output logic o_sample,
    output logic o_symbol_edge
);

    localparam int              CW      = (SYMBOL_TIME > 2) ? $clog2(SYMBOL_TIME) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SYMBOL_TIME - 1);
    localparam logic [CW-1:0]   CNT_SAMP = CW'(SAMPLE_AT);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_srst || i_clear || (r_count == CNT_LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_sample      = (r_count == CNT_SAMP);
    assign o_symbol_edge = (r_count == CNT_LAST);

endmodule

// File: rtl/uart_receiver_cfg.sv
// ---------------------------------------------------------------------------
// uart_receiver_cfg
// Configurable UART receiver: DATA_BITS data bits (LSB first), optional
// even/odd parity, 1 or 2 stop bits. Input is double-flopped, false starts
// are rejected, parity/framing errors travel with the word, and a one-entry
// holding register offers the word with valid/ready. A frame completing
// while the holding register is full and not draining is dropped and
// flagged with a one-cycle overrun pulse.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   serial_in            : asynchronous RX line, idle high
//   data_out             : received word
//   data_out_parity_err  : parity mismatch for data_out
//   data_out_frame_err   : a stop bit of data_out was sampled low
//   data_out_valid       : holding register full
//   data_out_ready       : consumer accepts when valid && ready
//   overrun              : completed frame dropped (1-cycle pulse)
// Build option:
//   UART_RX_MAJORITY_VOTE_EN : each bit is the 2-of-3 vote of the samples at
//   SAMPLE_TIME-1/SAMPLE_TIME/SAMPLE_TIME+1, decided at SAMPLE_TIME+1.
//   Undefined: single sample at SAMPLE_TIME.
// ---------------------------------------------------------------------------
module uart_receiver_cfg
    import uart_pkg::*;
#(
    parameter int      CLOCK_FREQ = 125_000_000,
    parameter int      BAUD_RATE  = 115_200,
    parameter int      DATA_BITS  = 8,
    parameter parity_e PARITY     = PARITY_NONE,
    parameter int      STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_parity_err,
    output logic                 data_out_frame_err,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 overrun
);

    localparam int SYMBOL_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME = SYMBOL_TIME / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int SAMPLE_AT   = SAMPLE_TIME + 1;
`else
    localparam int SAMPLE_AT   = SAMPLE_TIME;
`endif
    localparam int BW = $clog2(DATA_BITS + 1);

    // Input synchroniser, idles high so reset does not look like a start bit
    logic r_sync1, r_sync2;
    logic w_rx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;

    // Bit decision presented at the sample strobe
    logic w_bit;
`ifdef UART_RX_MAJORITY_VOTE_EN
    // [1] = rx at SAMPLE_TIME-1, [0] = rx at SAMPLE_TIME when the strobe fires
    logic [1:0] r_rx_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_hist <= 2'b11;
        end else begin
            r_rx_hist <= {r_rx_hist[0], w_rx};
        end
    end

    assign w_bit = (r_rx_hist[1] & r_rx_hist[0]) | (r_rx_hist[1] & w_rx) |
                   (r_rx_hist[0] & w_rx);
`else
    assign w_bit = w_rx;
`endif

    // Symbol timing
    logic w_clear, w_sample, w_symbol_edge;

    uart_baud_tick #(
        .SYMBOL_TIME (SYMBOL_TIME),
        .SAMPLE_AT   (SAMPLE_AT)
    ) u_baud_tick (
        .clk           (clk),
        .i_srst        (reset),
        .i_clear       (w_clear),
        .o_sample      (w_sample),
        .o_symbol_edge (w_symbol_edge)
    );

    // Frame FSM
    rx_state_e r_state, w_state_next;
    logic      w_complete;

    logic [BW-1:0]        r_bit_cnt;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity_err;
    logic                 r_frame_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx) begin
                    w_state_next = ST_START;
                    w_clear      = 1'b1;
                end
            end
            ST_START: begin
                // A line back high at mid-bit was only a glitch
                if (w_sample && w_bit) begin
                    w_state_next = ST_IDLE;
                end else if (w_symbol_edge) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_symbol_edge && (r_bit_cnt == BW'(DATA_BITS))) begin
                    w_state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_symbol_edge) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Finish at mid final stop bit so a back-to-back start edge is seen
                if (w_sample && (r_stop_cnt == 1'(STOP_BITS - 1))) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Zero-extended view of the shift register for the parity helper
    logic [MAX_DATA_BITS-1:0] w_data_ext;

    always_comb begin
        w_data_ext                = '0;
        w_data_ext[DATA_BITS-1:0] = r_shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_shift      <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt    <= '0;
                    r_stop_cnt   <= 1'b0;
                    r_parity_err <= 1'b0;
                    r_frame_err  <= 1'b0;
                end
                ST_DATA: begin
                    if (w_sample) begin
                        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                    end
                end
                ST_PARITY: begin
                    if (w_sample) begin
                        r_parity_err <= (w_bit != calc_parity(w_data_ext, PARITY));
                    end
                end
                ST_STOP: begin
                    if (w_sample) begin
                        if (!w_bit) begin
                            r_frame_err <= 1'b1;
                        end
                        r_stop_cnt <= r_stop_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // One-entry holding register
    logic [DATA_BITS-1:0] r_data;
    logic                 r_data_parity_err;
    logic                 r_data_frame_err;
    logic                 r_valid;
    logic                 r_overrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data            <= '0;
            r_data_parity_err <= 1'b0;
            r_data_frame_err  <= 1'b0;
            r_valid           <= 1'b0;
            r_overrun         <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete && (!r_valid || data_out_ready)) begin
                r_data            <= r_shift;
                r_data_parity_err <= r_parity_err;
                r_data_frame_err  <= r_frame_err | ~w_bit;
                r_valid           <= 1'b1;
            end else begin
                if (w_complete) begin
                    r_overrun <= 1'b1;
                end
                if (r_valid && data_out_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign data_out            = r_data;
    assign data_out_parity_err = r_data_parity_err;
    assign data_out_frame_err  = r_data_frame_err;
    assign data_out_valid      = r_valid;
    assign overrun             = r_overrun;

endmodule

// File: tb/tb_uart_receiver_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver_cfg
// Three receivers share clock and reset:
//   u_a : default parameters (8N1, 1085-cycle symbols)
//   u_b : 8E1, 16-cycle symbols
//   u_c : 7O2, 16-cycle symbols
// Frames are driven bit by bit; a monitor logs every accepted beat and
// counts overrun pulses. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_uart_receiver_cfg;
    import uart_pkg::*;

    localparam int SYM_A = 125_000_000 / 115_200;
    localparam int SYM_S = 1600 / 100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic       ser_a = 1'b1, rdy_a = 1'b1;
    logic [7:0] dat_a;
    logic       perr_a, ferr_a, val_a, ovr_a;

    logic       ser_b = 1'b1, rdy_b = 1'b1;
    logic [7:0] dat_b;
    logic       perr_b, ferr_b, val_b, ovr_b;

    logic       ser_c = 1'b1, rdy_c = 1'b1;
    logic [6:0] dat_c;
    logic       perr_c, ferr_c, val_c, ovr_c;

    uart_receiver_cfg u_a (
        .clk(clk), .reset(rst), .serial_in(ser_a), .data_out(dat_a),
        .data_out_parity_err(perr_a), .data_out_frame_err(ferr_a),
        .data_out_valid(val_a), .data_out_ready(rdy_a), .overrun(ovr_a)
    );

    uart_receiver_cfg #(
        .CLOCK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8),
        .PARITY(PARITY_EVEN), .STOP_BITS(1)
    ) u_b (
        .clk(clk), .reset(rst), .serial_in(ser_b), .data_out(dat_b),
        .data_out_parity_err(perr_b), .data_out_frame_err(ferr_b),
        .data_out_valid(val_b), .data_out_ready(rdy_b), .overrun(ovr_b)
    );

    uart_receiver_cfg #(
        .CLOCK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(7),
        .PARITY(PARITY_ODD), .STOP_BITS(2)
    ) u_c (
        .clk(clk), .reset(rst), .serial_in(ser_c), .data_out(dat_c),
        .data_out_parity_err(perr_c), .data_out_frame_err(ferr_c),
        .data_out_valid(val_c), .data_out_ready(rdy_c), .overrun(ovr_c)
    );

    int total = 0;
    int bad   = 0;

    // beat = {parity_err, frame_err, data[8:0]}
    logic [10:0] q_a[$];
    logic [10:0] q_b[$];
    logic [10:0] q_c[$];
    int          ovr_cnt_a = 0;
    int          ovr_cnt_b = 0;
    int          ovr_cnt_c = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled on the falling edge, inputs change 1 time unit after the rising edge
    always @(negedge clk) begin
        if (val_a && rdy_a) begin
            q_a.push_back({perr_a, ferr_a, 1'b0, dat_a});
            $display("beat a data=%02h perr=%b ferr=%b", dat_a, perr_a, ferr_a);
        end
        if (val_b && rdy_b) begin
            q_b.push_back({perr_b, ferr_b, 1'b0, dat_b});
            $display("beat b data=%02h perr=%b ferr=%b", dat_b, perr_b, ferr_b);
        end
        if (val_c && rdy_c) begin
            q_c.push_back({perr_c, ferr_c, 2'b00, dat_c});
            $display("beat c data=%02h perr=%b ferr=%b", dat_c, perr_c, ferr_c);
        end
        if (ovr_a) ovr_cnt_a++;
        if (ovr_b) ovr_cnt_b++;
        if (ovr_c) ovr_cnt_c++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int which, input logic v);
        case (which)
            0:       ser_a = v;
            1:       ser_b = v;
            default: ser_c = v;
        endcase
    endtask

    function automatic int qsize(input int which);
        case (which)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    // par < 0 means no parity bit; otherwise par[0] is the bit driven
    task automatic send_frame(input int which, input int sym, input logic [8:0] data,
                              input int nbits, input int par, input logic s1,
                              input logic s2, input int nstop);
        set_line(which, 1'b0);
        wait_cyc(sym);
        for (int i = 0; i < nbits; i++) begin
            set_line(which, data[i]);
            wait_cyc(sym);
        end
        if (par >= 0) begin
            set_line(which, par[0]);
            wait_cyc(sym);
        end
        set_line(which, s1);
        wait_cyc(sym);
        if (nstop == 2) begin
            set_line(which, s2);
            wait_cyc(sym);
        end
        set_line(which, 1'b1);
    endtask

    task automatic get_beat(input string tag, input int which, input int budget,
                            output logic [10:0] beat);
        int n;
        n = qsize(which);
        for (int i = 0; i < budget && n == 0; i++) begin
            @(posedge clk);
            n = qsize(which);
        end
        #1;
        check_val({tag, "_arrived"}, 32'(n != 0), 32'd1);
        beat = '1;
        if (n != 0) begin
            case (which)
                0:       beat = q_a.pop_front();
                1:       beat = q_b.pop_front();
                default: beat = q_c.pop_front();
            endcase
        end
    endtask

    task automatic check_beat(input string tag, input logic [10:0] beat,
                              input logic [8:0] exp_data, input logic exp_perr,
                              input logic exp_ferr);
        check_val({tag, "_data"}, 32'(beat[8:0]), 32'(exp_data));
        check_val({tag, "_perr"}, 32'(beat[10]), 32'(exp_perr));
        check_val({tag, "_ferr"}, 32'(beat[9]), 32'(exp_ferr));
    endtask

    initial begin
        logic [10:0] beat;

        // Reset state
        wait_cyc(5);
        check_val("rst_valid_a", 32'(val_a), 32'd0);
        check_val("rst_data_a", 32'(dat_a), 32'd0);
        check_val("rst_perr_a", 32'(perr_a), 32'd0);
        check_val("rst_ferr_a", 32'(ferr_a), 32'd0);
        check_val("rst_ovr_a", 32'(ovr_a), 32'd0);
        check_val("rst_valid_b", 32'(val_b), 32'd0);
        rst = 1'b0;
        wait_cyc(5);

        // 8N1 0xA5
        send_frame(0, SYM_A, 9'h0A5, 8, -1, 1'b1, 1'b1, 1);
        get_beat("a5", 0, 3000, beat);
        check_beat("a5", beat, 9'h0A5, 1'b0, 1'b0);
        wait_cyc(20);
        check_val("a5_single", 32'(q_a.size()), 32'd0);
        check_val("a5_no_ovr", 32'(ovr_cnt_a), 32'd0);

        // 8E1: 0x03 has even parity bit 0, so parity bit 1 is an error
        send_frame(1, SYM_S, 9'h003, 8, 1, 1'b1, 1'b1, 1);
        get_beat("e_bad", 1, 100, beat);
        check_beat("e_bad", beat, 9'h003, 1'b1, 1'b0);
        send_frame(1, SYM_S, 9'h003, 8, 0, 1'b1, 1'b1, 1);
        get_beat("e_ok", 1, 100, beat);
        check_beat("e_ok", beat, 9'h003, 1'b0, 1'b0);

        // 7O2: 0x41 has two ones, odd parity bit is 1
        send_frame(2, SYM_S, 9'h041, 7, 1, 1'b1, 1'b0, 2);
        get_beat("o_ferr", 2, 100, beat);
        check_beat("o_ferr", beat, 9'h041, 1'b0, 1'b1);
        wait_cyc(40);
        send_frame(2, SYM_S, 9'h041, 7, 1, 1'b1, 1'b1, 2);
        get_beat("o_ok", 2, 100, beat);
        check_beat("o_ok", beat, 9'h041, 1'b0, 1'b0);

        // Backpressure: two back-to-back frames, second one overruns
        rdy_b = 1'b0;
        send_frame(1, SYM_S, 9'h011, 8, 0, 1'b1, 1'b1, 1);
        send_frame(1, SYM_S, 9'h022, 8, 0, 1'b1, 1'b1, 1);
        wait_cyc(10);
        check_val("bp_valid", 32'(val_b), 32'd1);
        check_val("bp_data", 32'(dat_b), 32'h11);
        check_val("bp_ovr_cnt", 32'(ovr_cnt_b), 32'd1);
        rdy_b = 1'b1;
        wait_cyc(3);
        check_val("bp_drained", 32'(val_b), 32'd0);
        get_beat("bp", 1, 10, beat);
        check_beat("bp", beat, 9'h011, 1'b0, 1'b0);
        check_val("bp_single", 32'(q_b.size()), 32'd0);
        check_val("bp_ovr_final", 32'(ovr_cnt_b), 32'd1);

        // Glitch shorter than half a symbol is rejected
        ser_a = 1'b0;
        wait_cyc(200);
        ser_a = 1'b1;
        wait_cyc(1500);
        check_val("glitch_no_beat", 32'(q_a.size()), 32'd0);
        check_val("glitch_valid", 32'(val_a), 32'd0);
        send_frame(0, SYM_A, 9'h05A, 8, -1, 1'b1, 1'b1, 1);
        get_beat("post_glitch", 0, 3000, beat);
        check_beat("post_glitch", beat, 9'h05A, 1'b0, 1'b0);

        // Reset in the middle of an 0xFF frame
        ser_a = 1'b0;
        wait_cyc(SYM_A);
        ser_a = 1'b1;
        wait_cyc(3 * SYM_A);
        rst = 1'b1;
        wait_cyc(1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("rst_mid_valid", 32'(val_a), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cyc(10 * SYM_A);
        check_val("rst_mid_no_beat", 32'(q_a.size()), 32'd0);
        send_frame(0, SYM_A, 9'h00F, 8, -1, 1'b1, 1'b1, 1);
        get_beat("post_rst", 0, 3000, beat);
        check_beat("post_rst", beat, 9'h00F, 1'b0, 1'b0);
        wait_cyc(20);
        check_val("post_rst_single", 32'(q_a.size()), 32'd0);
        check_val("final_ovr_a", 32'(ovr_cnt_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
